mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Memory-side responder for the per-CPU icache/dcache request interface.
- Arbitrates instruction and data requests from CPUS processors onto one single-ported RAM.
- Returns read data and releases the wait signal to the granted requester.
- Sits between the caches blocks of each core and the system RAM.

Parameters:
CPUS, 2, number of cores; each core has one icache and one dcache requester port.
WORD_W, 32, data and address width.

Ports:
CLK  in  1  system clock, rising edge.
nRST  in  1  asynchronous active-low reset.
iREN  in  CPUS  instruction read request, one bit per CPU.
iaddr  in  CPUS*WORD_W  instruction address, CPU k at bits [k*WORD_W +: WORD_W].
dREN  in  CPUS  data read request.
dWEN  in  CPUS  data write request.
daddr  in  CPUS*WORD_W  data address.
dstore  in  CPUS*WORD_W  data write value.
iwait  out  CPUS  high = instruction request not complete.
dwait  out  CPUS  high = data request not complete.
iload  out  CPUS*WORD_W  instruction read data.
dload  out  CPUS*WORD_W  data read data.
ramREN  out  1  RAM read enable.
ramWEN  out  1  RAM write enable.
ramaddr  out  WORD_W  RAM address.
ramstore  out  WORD_W  RAM write data.
ramload  in  WORD_W  RAM read data.
ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
ram_err  out  1  one-cycle pulse when RAM reports ERROR for the active grant.

Behaviour:
- Reset (async, nRST low):
  - State = IDLE, rr_ptr = 0, grant cleared.
  - iwait and dwait all 1; ramREN = ramWEN = 0; ramaddr = ramstore = 0; ram_err = 0.
- Load buses:
  - Every iload/dload slice is continuously driven with ramload.
  - Load data is valid only in the cycle the matching wait bit is 0.
- Requester contract:
  - Hold REN/WEN, address and store data stable until it samples its wait bit low.
  - Completion consumes the request.
  - A requester may reassert in the cycle immediately after completion.
- State machine: IDLE, SERVE.
- IDLE:
  - All waits 1; RAM enables 0.
  - If any request is pending, register a grant and go to SERVE; otherwise stay.
- Arbitration (evaluated in IDLE):
  - Any data request (dREN|dWEN) beats any instruction request.
  - Within a class, round-robin: scan CPUs starting at rr_ptr, wrapping modulo CPUS.
  - If dWEN and dREN are both high for one CPU, it is treated as a write.
- SERVE:
  - ramaddr, ramstore, ramREN and ramWEN are driven combinationally from the granted requester's live inputs.
  - The granted wait bit stays 1 until ramstate == ACCESS.
  - In that ACCESS cycle, the granted wait bit = 0 (combinational).
  - Next state = IDLE; rr_ptr = (granted CPU + 1) mod CPUS.
  - ramstate FREE/BUSY: hold in SERVE, wait stays 1.
  - ramstate ERROR: ram_err = 1 that cycle, wait stays 1, remain in SERVE so the RAM retries.
  - Granted requester drops its enable while in SERVE: abort to IDLE next cycle; RAM enables go 0 in the same cycle; rr_ptr unchanged; no wait pulse.
- Latency: a request seen in IDLE at cycle N drives the RAM from cycle N+1. Minimum request-to-wait-low latency is 1 cycle with a zero-latency RAM (ACCESS in N+1).
- Non-granted requesters always see wait = 1.
- At most one RAM transaction is in flight; never more than one wait bit is low in a cycle.
- Reset asserted mid-SERVE: RAM enables drop immediately (async); the requester reissues after reset.

Test Plan:
- Reset: nRST low with all requests high -> iwait = 2'b11, dwait = 2'b11, ramREN = ramWEN = 0, ram_err = 0.
- Single read: CPU0 iREN, iaddr = 0x0000_0040; RAM gives ACCESS 2 cycles after ramREN with ramload = 0x2108_0004 -> ramaddr = 0x40, iwait[0] low for exactly 1 cycle, iload[0] = 0x2108_0004 that cycle.
- Data priority: CPU0 iREN and CPU1 dWEN (daddr = 0x80, dstore = 0xDEAD_BEEF) raised together -> write served first (ramWEN = 1, ramstore = 0xDEADBEEF), then the instruction read.
- Round-robin: both CPUs hold dREN continuously for 4 transactions -> grant order CPU0, CPU1, CPU0, CPU1; no back-to-back grant to the same CPU.
- Error/abort: ramstate = 3 for 2 cycles, then 2 -> ram_err pulses 2 cycles, dwait stays high until ACCESS. Separately, a requester drops dREN mid-SERVE -> IDLE next cycle, no wait pulse.
- Async reset mid-SERVE: nRST low while ramREN = 1 -> ramREN = 0 without a clock edge; after release, the held request is re-arbitrated and completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: memory-side responder for the per-CPU icache/dcache request
// interface. Grants one requester at a time onto a single-ported RAM. Data
// requests beat instruction requests, and each class is scanned round-robin.
// The RAM is driven straight from the granted requester's live inputs. Its wait
// bit is released combinationally in the cycle the RAM reports ACCESS.
module mem_bus_arbiter #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS*WORD_W-1:0]   iaddr,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS*WORD_W-1:0]   daddr,
    input  logic [CPUS*WORD_W-1:0]   dstore,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS*WORD_W-1:0]   iload,
    output logic [CPUS*WORD_W-1:0]   dload,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [WORD_W-1:0]        ramaddr,
    output logic [WORD_W-1:0]        ramstore,
    input  logic [WORD_W-1:0]        ramload,
    input  logic [1:0]               ramstate,
    output logic                     ram_err
);

    localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [PW-1:0] rr_ptr_reg, rr_ptr_next;
    logic [PW-1:0] grant_reg, grant_next;
    logic          grant_data_reg, grant_data_next;

    // Per-CPU views of the flattened buses
    logic [CPUS-1:0]   dreq;
    logic [WORD_W-1:0] iaddr_w  [CPUS];
    logic [WORD_W-1:0] daddr_w  [CPUS];
    logic [WORD_W-1:0] dstore_w [CPUS];

    // Arbitration results
    logic          d_found, i_found;
    logic [PW-1:0] d_pick, i_pick;
    logic [PW-1:0] scan_idx;
    logic          grant_active;

    genvar gi;
    generate
        for (gi = 0; gi < CPUS; gi++) begin : g_cpu
            assign dreq[gi]     = dREN[gi] | dWEN[gi];
            assign iaddr_w[gi]  = iaddr[gi*WORD_W +: WORD_W];
            assign daddr_w[gi]  = daddr[gi*WORD_W +: WORD_W];
            assign dstore_w[gi] = dstore[gi*WORD_W +: WORD_W];
            // Load buses simply mirror the RAM; wait bits qualify them
            assign iload[gi*WORD_W +: WORD_W] = ramload;
            assign dload[gi*WORD_W +: WORD_W] = ramload;
        end
    endgenerate

    // Round-robin scan of both request classes, starting at rr_ptr
    always_comb begin
        d_found  = 1'b0;
        i_found  = 1'b0;
        d_pick   = '0;
        i_pick   = '0;
        scan_idx = '0;
        for (int k = 0; k < CPUS; k++) begin
            scan_idx = PW'((int'(rr_ptr_reg) + k) % CPUS);
            if (!d_found && dreq[scan_idx]) begin
                d_found = 1'b1;
                d_pick  = scan_idx;
            end
            if (!i_found && iREN[scan_idx]) begin
                i_found = 1'b1;
                i_pick  = scan_idx;
            end
        end
    end

    // Next-state logic and RAM/wait outputs driven from the current grant
    always_comb begin
        state_next      = state_reg;
        rr_ptr_next     = rr_ptr_reg;
        grant_next      = grant_reg;
        grant_data_next = grant_data_reg;
        iwait           = '1;
        dwait           = '1;
        ramREN          = 1'b0;
        ramWEN          = 1'b0;
        ramaddr         = '0;
        ramstore        = '0;
        ram_err         = 1'b0;
        grant_active    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (d_found) begin
                    grant_next      = d_pick;
                    grant_data_next = 1'b1;
                    state_next      = SERVE;
                end else if (i_found) begin
                    grant_next      = i_pick;
                    grant_data_next = 1'b0;
                    state_next      = SERVE;
                end
            end

            SERVE: begin
                if (grant_data_reg) begin
                    // Read+write together on one port is served as a write
                    grant_active = dreq[grant_reg];
                    ramWEN       = dWEN[grant_reg];
                    ramREN       = dREN[grant_reg] & ~dWEN[grant_reg];
                    ramaddr      = daddr_w[grant_reg];
                    ramstore     = dstore_w[grant_reg];
                end else begin
                    grant_active = iREN[grant_reg];
                    ramREN       = iREN[grant_reg];
                    ramaddr      = iaddr_w[grant_reg];
                end

                if (!grant_active) begin
                    // Requester withdrew: abandon without a wait pulse
                    state_next = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    if (grant_data_reg) begin
                        dwait[grant_reg] = 1'b0;
                    end else begin
                        iwait[grant_reg] = 1'b0;
                    end
                    state_next  = IDLE;
                    rr_ptr_next = (grant_reg == PW'(CPUS - 1)) ? '0 : grant_reg + 1'b1;
                end else if (ramstate == RAM_ERROR) begin
                    // RAM retries on its own; just flag it for this cycle
                    ram_err = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, round-robin pointer and grant registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= '0;
            grant_reg      <= '0;
            grant_data_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            grant_reg      <= grant_next;
            grant_data_reg <= grant_data_next;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed vector table, async-reset sequence and a
// randomized run against a transaction-level model with a latency/error RAM.
module tb_mem_bus_arbiter;

    localparam int CPUS = 2;
    localparam int W    = 32;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

    logic              clk = 1'b0;
    logic              nrst;
    logic [CPUS-1:0]   iren, dren, dwen;
    logic [CPUS*W-1:0] iaddr, daddr, dstore;
    logic [CPUS-1:0]   iwait, dwait;
    logic [CPUS*W-1:0] iload, dload;
    logic              ramren, ramwen, ram_err;
    logic [W-1:0]      ramaddr, ramstore, ramload;
    logic [1:0]        ramstate;

    mem_bus_arbiter #(.CPUS(CPUS), .WORD_W(W)) dut (
        .CLK(clk), .nRST(nrst),
        .iREN(iren), .iaddr(iaddr),
        .dREN(dren), .dWEN(dwen), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramren), .ramWEN(ramwen), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  iren, dren, dwen, rs;
        logic [1:0]  e_iwait, e_dwait;
        logic        e_ren, e_wen;
        logic [31:0] e_addr;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic add_row(input logic [1:0] ir, input logic [1:0] dr, input logic [1:0] dw,
                           input logic [1:0] rs, input logic [1:0] eiw, input logic [1:0] edw,
                           input logic er, input logic ew, input logic [31:0] ea, input logic ee);
        vec_t v;
        v.iren = ir; v.dren = dr; v.dwen = dw; v.rs = rs;
        v.e_iwait = eiw; v.e_dwait = edw; v.e_ren = er; v.e_wen = ew;
        v.e_addr = ea; v.e_err = ee;
        tbl.push_back(v);
    endtask

    // ---------------- randomized-phase model ----------------
    // Ports 0..CPUS-1 are dcache ports, CPUS..2*CPUS-1 are icache ports.
    bit          req_act  [2*CPUS];
    bit          req_wr   [2*CPUS];
    bit          req_both [2*CPUS];
    logic [31:0] req_addr [2*CPUS];
    logic [31:0] req_data [2*CPUS];
    logic [31:0] model_mem[16];
    logic [31:0] ram_mem  [16];
    int cur, rr, lat, txn;
    bit in_txn;

    // Next winner: any data port beats any instruction port; round-robin from rr
    function automatic int pick();
        for (int o = 0; o < CPUS; o++)
            if (req_act[(rr + o) % CPUS]) return (rr + o) % CPUS;
        for (int o = 0; o < CPUS; o++)
            if (req_act[CPUS + (rr + o) % CPUS]) return CPUS + (rr + o) % CPUS;
        return -1;
    endfunction

    initial begin
        logic [1:0]  exp_iw, exp_dw;
        logic        exp_ren, exp_wen, exp_err;
        int          c;
        bit          isd;

        // Reset with every request high and the RAM shouting ERROR
        nrst = 1'b0; iren = '1; dren = '1; dwen = '1;
        iaddr = '1; daddr = '1; dstore = '1;
        ramstate = ERR; ramload = 32'h2108_0004;
        repeat (2) @(posedge clk);
        #1;
        check("reset iwait", iwait, 2'b11);
        check("reset dwait", dwait, 2'b11);
        check("reset ramREN/WEN", {ramren, ramwen}, 2'b00);
        check("reset ram_err", ram_err, 1'b0);
        check("reset ramaddr", ramaddr, 32'h0);
        check("reset ramstore", ramstore, 32'h0);
        iren = '0; dren = '0; dwen = '0; ramstate = FREE;
        iaddr  = {32'h0000_0044, 32'h0000_0040};
        daddr  = {32'h0000_0080, 32'h0000_0100};
        dstore = {32'hDEAD_BEEF, 32'h1111_0000};
        #2 nrst = 1'b1;

        // iren dren dwen rs   iwait dwait ren wen addr err
        add_row(2'b01, 2'b00, 2'b00, FREE, 2'b11, 2'b11, 0, 0, 32'h0,   0); // single read
        add_row(2'b01, 2'b00, 2'b00, BUSY, 2'b11, 2'b11, 1, 0, 32'h40,  0);
        add_row(2'b01, 2'b00, 2'b00, BUSY, 2'b11, 2'b11, 1, 0, 32'h40,  0);
        add_row(2'b01, 2'b00, 2'b00, ACC,  2'b10, 2'b11, 1, 0, 32'h40,  0);
        add_row(2'b01, 2'b00, 2'b10, FREE, 2'b11, 2'b11, 0, 0, 32'h0,   0); // data priority
        add_row(2'b01, 2'b00, 2'b10, ACC,  2'b11, 2'b01, 0, 1, 32'h80,  0);
        add_row(2'b01, 2'b00, 2'b00, FREE, 2'b11, 2'b11, 0, 0, 32'h0,   0);
        add_row(2'b01, 2'b00, 2'b00, ACC,  2'b10, 2'b11, 1, 0, 32'h40,  0);
        add_row(2'b10, 2'b00, 2'b00, FREE, 2'b11, 2'b11, 0, 0, 32'h0,   0); // rr -> 0
        add_row(2'b10, 2'b00, 2'b00, ACC,  2'b01, 2'b11, 1, 0, 32'h44,  0);
        add_row(2'b00, 2'b11, 2'b00, FREE, 2'b11, 2'b11, 0, 0, 32'h0,   0); // round-robin
        add_row(2'b00, 2'b11, 2'b00, ACC,  2'b11, 2'b10, 1, 0, 32'h100, 0);
        add_row(2'b00, 2'b11, 2'b00, FREE, 2'b11, 2'b11, 0, 0, 32'h0,   0);
        add_row(2'b00, 2'b11, 2'b00, ACC,  2'b11, 2'b01, 1, 0, 32'h80,  0);
        add_row(2'b00, 2'b11, 2'b00, FREE, 2'b11, 2'b11, 0, 0, 32'h0,   0);
        add_row(2'b00, 2'b11, 2'b00, ACC,  2'b11, 2'b10, 1, 0, 32'h100, 0);
        add_row(2'b00, 2'b11, 2'b00, FREE, 2'b11, 2'b11, 0, 0, 32'h0,   0);
        add_row(2'b00, 2'b11, 2'b00, ACC,  2'b11, 2'b01, 1, 0, 32'h80,  0);
        add_row(2'b00, 2'b01, 2'b00, FREE, 2'b11, 2'b11, 0, 0, 32'h0,   0); // error retry
        add_row(2'b00, 2'b01, 2'b00, ERR,  2'b11, 2'b11, 1, 0, 32'h100, 1);
        add_row(2'b00, 2'b01, 2'b00, ERR,  2'b11, 2'b11, 1, 0, 32'h100, 1);
        add_row(2'b00, 2'b01, 2'b00, ACC,  2'b11, 2'b10, 1, 0, 32'h100, 0);
        add_row(2'b00, 2'b10, 2'b00, FREE, 2'b11, 2'b11, 0, 0, 32'h0,   0); // abort
        add_row(2'b00, 2'b10, 2'b00, BUSY, 2'b11, 2'b11, 1, 0, 32'h80,  0);
        add_row(2'b00, 2'b00, 2'b00, ACC,  2'b11, 2'b11, 0, 0, 32'h0,   0);
        add_row(2'b00, 2'b11, 2'b00, FREE, 2'b11, 2'b11, 0, 0, 32'h0,   0); // rr kept at 1
        add_row(2'b00, 2'b11, 2'b00, ACC,  2'b11, 2'b01, 1, 0, 32'h80,  0);
        add_row(2'b00, 2'b01, 2'b00, FREE, 2'b11, 2'b11, 0, 0, 32'h0,   0);
        add_row(2'b00, 2'b01, 2'b00, ACC,  2'b11, 2'b10, 1, 0, 32'h100, 0);
        add_row(2'b00, 2'b00, 2'b00, FREE, 2'b11, 2'b11, 0, 0, 32'h0,   0);

        for (int r = 0; r < tbl.size(); r++) begin
            @(posedge clk); #1;
            iren = tbl[r].iren; dren = tbl[r].dren; dwen = tbl[r].dwen;
            ramstate = tbl[r].rs;
            #2;
            $display("row %0d: iwait=%b dwait=%b ren=%b wen=%b addr=%0h err=%b",
                     r, iwait, dwait, ramren, ramwen, ramaddr, ram_err);
            check($sformatf("row%0d iwait", r), iwait, tbl[r].e_iwait);
            check($sformatf("row%0d dwait", r), dwait, tbl[r].e_dwait);
            check($sformatf("row%0d ren/wen", r), {ramren, ramwen}, {tbl[r].e_ren, tbl[r].e_wen});
            check($sformatf("row%0d ram_err", r), ram_err, tbl[r].e_err);
            if (tbl[r].e_ren || tbl[r].e_wen)
                check($sformatf("row%0d ramaddr", r), ramaddr, tbl[r].e_addr);
            if (tbl[r].e_wen)
                check($sformatf("row%0d ramstore", r), ramstore, 32'hDEAD_BEEF);
            for (int k = 0; k < CPUS; k++) begin
                if (!tbl[r].e_iwait[k])
                    check($sformatf("row%0d iload%0d", r, k), iload[k*W +: W], 32'h2108_0004);
                if (!tbl[r].e_dwait[k])
                    check($sformatf("row%0d dload%0d", r, k), dload[k*W +: W], 32'h2108_0004);
            end
        end

        // Async reset in the middle of a SERVE, then reissue
        @(posedge clk); #1; dren = 2'b01; ramstate = BUSY; #2;
        check("areset idle ren", ramren, 1'b0);
        @(posedge clk); #3;
        check("areset serve ren", ramren, 1'b1);
        check("areset serve addr", ramaddr, 32'h100);
        #1 nrst = 1'b0;
        #1;
        check("areset ren drop", {ramren, ramwen}, 2'b00);
        check("areset dwait", dwait, 2'b11);
        #2 nrst = 1'b1;
        @(posedge clk); #1; ramstate = ACC; #2;
        $display("reissue: dwait=%b ren=%b addr=%0h", dwait, ramren, ramaddr);
        check("reissue dwait", dwait, 2'b10);
        check("reissue ren", ramren, 1'b1);
        check("reissue dload0", dload[0 +: W], 32'h2108_0004);
        @(posedge clk); #1; dren = 2'b00; ramstate = FREE;

        // Fresh reset for the randomized run so the model starts from rr = 0
        @(posedge clk); #1; nrst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ram_mem[i]   = $urandom;
            model_mem[i] = ram_mem[i];
        end
        for (int p = 0; p < 2*CPUS; p++) req_act[p] = 1'b0;
        cur = -1; rr = 0; lat = 0; in_txn = 1'b0; txn = 0;
        #3 nrst = 1'b1;

        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clk); #1;
            // Requesters: idle ports occasionally raise a new request
            for (int p = 0; p < 2*CPUS; p++) begin
                if (!req_act[p] && $urandom_range(0, 3) == 0) begin
                    req_act[p]  = 1'b1;
                    req_addr[p] = 32'($urandom_range(0, 15)) << 2;
                    req_data[p] = $urandom;
                    req_wr[p]   = (p < CPUS) ? 1'($urandom_range(0, 1)) : 1'b0;
                    req_both[p] = req_wr[p] & 1'($urandom_range(0, 1));
                end
            end
            for (int k = 0; k < CPUS; k++) begin
                iren[k]          = req_act[CPUS+k];
                iaddr[k*W +: W]  = req_act[CPUS+k] ? req_addr[CPUS+k] : $urandom;
                dwen[k]          = req_act[k] & req_wr[k];
                dren[k]          = req_act[k] & (!req_wr[k] | req_both[k]);
                daddr[k*W +: W]  = req_act[k] ? req_addr[k] : $urandom;
                dstore[k*W +: W] = req_act[k] ? req_data[k] : $urandom;
            end
            #1;
            // RAM device: random latency, error cycles before access
            ramload = $urandom;
            if (ramren || ramwen) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    lat = $urandom_range(0, 3);
                end
                if (lat == 0) begin
                    ramstate = ACC;
                    if (ramren) ramload = ram_mem[ramaddr[5:2]];
                end else if ($urandom_range(0, 3) == 0) begin
                    ramstate = ERR;
                end else begin
                    ramstate = BUSY;
                    lat--;
                end
            end else begin
                in_txn = 1'b0;
                ramstate = FREE;
            end
            #1;
            // Expected outputs from the model's idea of the current grant
            exp_iw = '1; exp_dw = '1; exp_ren = 1'b0; exp_wen = 1'b0; exp_err = 1'b0;
            c = 0; isd = 1'b0;
            if (cur >= 0) begin
                c   = cur % CPUS;
                isd = (cur < CPUS);
                exp_wen = isd & req_wr[cur];
                exp_ren = !(isd & req_wr[cur]);
                if (ramstate == ACC) begin
                    if (isd) exp_dw[c] = 1'b0;
                    else     exp_iw[c] = 1'b0;
                end
                exp_err = (ramstate == ERR);
            end
            check("rand iwait", iwait, exp_iw);
            check("rand dwait", dwait, exp_dw);
            check("rand ren/wen", {ramren, ramwen}, {exp_ren, exp_wen});
            check("rand ram_err", ram_err, exp_err);
            if (cur >= 0) begin
                check("rand ramaddr", ramaddr, req_addr[cur]);
                if (isd && req_wr[cur]) check("rand ramstore", ramstore, req_data[cur]);
                if (ramstate == ACC && !(isd && req_wr[cur])) begin
                    if (isd) check("rand dload", dload[c*W +: W], model_mem[req_addr[cur][5:2]]);
                    else     check("rand iload", iload[c*W +: W], model_mem[req_addr[cur][5:2]]);
                end
            end
            // RAM commits what the DUT actually presented
            if (ramstate == ACC && ramwen) ram_mem[ramaddr[5:2]] = ramstore;
            if (ramstate == ACC) in_txn = 1'b0;
            // Model advance
            if (cur < 0) begin
                cur = pick();
            end else if (ramstate == ACC) begin
                txn++;
                $display("txn %0d: %s%0d %s addr=%0h", txn, isd ? "d" : "i", c,
                         (isd && req_wr[cur]) ? "write" : "read", req_addr[cur]);
                if (isd && req_wr[cur]) model_mem[req_addr[cur][5:2]] = req_data[cur];
                req_act[cur] = 1'b0;
                rr  = (c + 1) % CPUS;
                cur = -1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
